// File: rtl/rf_ctrl_pkg.sv
// rtl/rf_ctrl_pkg.sv - shared types and constants for the register-file write controller
package rf_ctrl_pkg;
    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int NUM_REGS   = 32;
    localparam int REG_ZERO   = 0;
    localparam int CLEAR_LAST = 31;
endpackage

// File: rtl/rf_write_arbiter_if.sv
// rtl/rf_write_arbiter_if.sv - WB/MDU request and register-file write-port bundle
interface rf_write_arbiter_if #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                       wb_we;
    logic [ADDR_WIDTH-1:0]      wb_addr;
    logic [WIDTH-1:0]           wb_data;
    logic                       md_valid;
    logic                       md_ready;
    logic [ADDR_WIDTH-1:0]      md_addr;
    logic [WIDTH-1:0]           md_data;
    logic                       RegWrite;
    logic [ADDR_WIDTH-1:0]      W_addr;
    logic [WIDTH-1:0]           W_data;
    logic                       busy;
    logic [2**ADDR_WIDTH-1:0]   pending;

    modport master (
        output wb_we, wb_addr, wb_data, md_valid, md_addr, md_data,
        input  md_ready, RegWrite, W_addr, W_data, busy, pending
    );

    modport slave (
        input  wb_we, wb_addr, wb_data, md_valid, md_addr, md_data,
        output md_ready, RegWrite, W_addr, W_data, busy, pending
    );
endinterface

// File: rtl/rf_wr_fifo.sv
// rtl/rf_wr_fifo.sv - MDU result buffer with per-entry squash and decoded pending mask
module rf_wr_fifo #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [ADDR_WIDTH-1:0]    i_push_addr,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    input  logic                     i_sq_en,
    input  logic [ADDR_WIDTH-1:0]    i_sq_addr,
    output logic                     o_full,
    output logic                     o_empty,
    output logic                     o_head_live,
    output logic [ADDR_WIDTH-1:0]    o_head_addr,
    output logic [WIDTH-1:0]         o_head_data,
    output logic [2**ADDR_WIDTH-1:0] o_pending
);
    localparam int PW = $clog2(DEPTH);

    logic                  r_live [DEPTH];
    logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
    logic [WIDTH-1:0]      r_data [DEPTH];
    logic [PW-1:0]         r_wr;
    logic [PW-1:0]         r_rd;
    logic [PW:0]           r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) r_live[i] <= 1'b0;
        end else begin
            // Squashed entries keep their slot until popped, but stop counting as pending.
            for (int i = 0; i < DEPTH; i++)
                if (i_sq_en && r_addr[i] == i_sq_addr) r_live[i] <= 1'b0;
            if (i_pop) begin
                r_live[r_rd] <= 1'b0;
                r_rd         <= r_rd + PW'(1);
            end
            if (i_push) begin
                r_live[r_wr] <= 1'b1;
                r_addr[r_wr] <= i_push_addr;
                r_data[r_wr] <= i_push_data;
                r_wr         <= r_wr + PW'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_cnt <= r_cnt + (PW+1)'(1);
                2'b01:   r_cnt <= r_cnt - (PW+1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_comb begin
        o_pending = '0;
        for (int i = 0; i < DEPTH; i++)
            if (r_live[i]) o_pending[r_addr[i]] = 1'b1;
    end

    assign o_full      = (r_cnt == (PW+1)'(DEPTH));
    assign o_empty     = (r_cnt == '0);
    assign o_head_live = r_live[r_rd];
    assign o_head_addr = r_addr[r_rd];
    assign o_head_data = r_data[r_rd];
endmodule

// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - register-file write-port owner: reset clear, WB/MDU arbitration
module rf_write_arbiter
    import rf_ctrl_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int FIFO_DEPTH = 2
) (
    input logic                clk,
    input logic                rst,
    rf_write_arbiter_if.slave  bus
);
    state_t                r_state;
    state_t                w_state_nx;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic                  r_done;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [WIDTH-1:0]      r_wdata;

    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [WIDTH-1:0]      w_data;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_wb_win;
    logic                  w_md_ready;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_head_live;
    logic [ADDR_WIDTH-1:0] w_head_addr;
    logic [WIDTH-1:0]      w_head_data;
    logic [2**ADDR_WIDTH-1:0] w_pending;

    assign w_wb_win   = (r_state == RUN) && bus.wb_we && (bus.wb_addr != ADDR_WIDTH'(REG_ZERO));
    assign w_md_ready = (r_state == RUN) && !w_full;
    // Zero-destination results and results overwritten by a same-edge WB never enter the buffer.
    assign w_push     = bus.md_valid && w_md_ready && (bus.md_addr != ADDR_WIDTH'(REG_ZERO))
                        && !(w_wb_win && bus.wb_addr == bus.md_addr);

    always_comb begin
        w_state_nx = r_state;
        w_we       = 1'b0;
        w_addr     = '0;
        w_data     = '0;
        w_pop      = 1'b0;
        case (r_state)
            INIT: begin
                if (r_done) begin
                    w_state_nx = RUN;
                end else begin
                    w_we   = 1'b1;
                    w_addr = r_cnt;
                end
            end
            RUN: begin
                if (w_wb_win) begin
                    w_we   = 1'b1;
                    w_addr = bus.wb_addr;
                    w_data = bus.wb_data;
                end else if (!w_empty) begin
                    w_pop = 1'b1;
                    if (w_head_live) begin
                        w_we   = 1'b1;
                        w_addr = w_head_addr;
                        w_data = w_head_data;
                    end
                end
            end
            default: w_state_nx = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= INIT;
            r_cnt   <= ADDR_WIDTH'(1);
            r_done  <= 1'b0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_state_nx;
            r_we    <= w_we;
            r_waddr <= w_addr;
            r_wdata <= w_data;
            if (r_state == INIT && !r_done) begin
                r_cnt <= r_cnt + ADDR_WIDTH'(1);
                if (r_cnt == ADDR_WIDTH'(CLEAR_LAST)) r_done <= 1'b1;
            end
        end
    end

    rf_wr_fifo #(
        .WIDTH      (WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_addr (bus.md_addr),
        .i_push_data (bus.md_data),
        .i_pop       (w_pop),
        .i_sq_en     (w_wb_win),
        .i_sq_addr   (bus.wb_addr),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_head_live (w_head_live),
        .o_head_addr (w_head_addr),
        .o_head_data (w_head_data),
        .o_pending   (w_pending)
    );

    assign bus.md_ready = w_md_ready;
    assign bus.RegWrite = r_we;
    assign bus.W_addr   = r_waddr;
    assign bus.W_data   = r_wdata;
    assign bus.busy     = (r_state == INIT);
    assign bus.pending  = w_pending;
endmodule
